ipf_lcu_feeder: RTL

IPF_LCU_FEEDER -- requirements
Module: ipf_lcu_feeder

---
 rtl/ipf_lcu_feeder.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/ipf_lcu_feeder.sv
// Streams an image to the pixel filter one LCU at a time, raster order, fetching per-LCU parameters first.
// Latency: img_rd -> in_en/din 2 cycles; from row 2 onward each row waits for the filter's busy pulse before the next row.
module ipf_lcu_feeder #(
    parameter int IMG_W  = 128,
    parameter int ADDR_W = 14,
    parameter int PAR_W  = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        cfg_lcu_size,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [7:0]        img_data,
    output logic              par_rd,
    output logic [5:0]        par_addr,
    input  logic [PAR_W-1:0]  par_data,
    input  logic              busy,
    input  logic              finish,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        ipf_type,
    output logic [4:0]        ipf_band_pos,
    output logic              ipf_wo_class,
    output logic [15:0]       ipf_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    localparam int LOG_W = $clog2(IMG_W);

    typedef enum logic [2:0] {
        IDLE, PAR, PARW, STREAM, HOLD, RESUME, DRAIN, DONE
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          lcu_size_q, lcu_size_d;
    logic [2:0]          lcu_x_q, lcu_x_d;
    logic [2:0]          lcu_y_q, lcu_y_d;
    logic [6:0]          row_q, row_d;
    logic [6:0]          col_q, col_d;
    logic [5:0]          par_addr_q, par_addr_d;
    logic                img_rd_q, img_rd_d;
    logic [ADDR_W-1:0]   img_addr_q, img_addr_d;
    logic                rd_d1_q;
    logic                in_en_q;
    logic [7:0]          din_q;
    logic [1:0]          type_q, type_d;
    logic [4:0]          band_q, band_d;
    logic                wo_q, wo_d;
    logic [15:0]         off_q, off_d;
    logic                done_q, done_d;

    logic [6:0]          s_last;
    logic [2:0]          n_last;
    logic [2:0]          lg_n;
    logic [2:0]          shamt;
    logic [ADDR_W-1:0]   ypix, xpix, cur_addr;
    logic [2:0]          nx_x, nx_y;

    always_comb begin
        unique case (lcu_size_q)
            2'd0:    s_last = 7'd15;
            2'd1:    s_last = 7'd31;
            default: s_last = 7'd63;
        endcase
        n_last   = 3'((IMG_W >> (32'd4 + 32'(lcu_size_q))) - 1);
        lg_n     = 3'(LOG_W - 4) - {1'b0, lcu_size_q};
        shamt    = 3'd4 + {1'b0, lcu_size_q};
        ypix     = (ADDR_W'(lcu_y_q) << shamt) + ADDR_W'(row_q);
        xpix     = (ADDR_W'(lcu_x_q) << shamt) + ADDR_W'(col_q);
        cur_addr = (ypix << LOG_W) + xpix;
        nx_x     = (lcu_x_q == n_last) ? 3'd0 : lcu_x_q + 3'd1;
        nx_y     = (lcu_x_q == n_last) ? lcu_y_q + 3'd1 : lcu_y_q;
    end

    always_comb begin
        state_d    = state_q;
        lcu_size_d = lcu_size_q;
        lcu_x_d    = lcu_x_q;
        lcu_y_d    = lcu_y_q;
        row_d      = row_q;
        col_d      = col_q;
        par_addr_d = par_addr_q;
        img_rd_d   = 1'b0;
        img_addr_d = img_addr_q;
        type_d     = type_q;
        band_d     = band_q;
        wo_d       = wo_q;
        off_d      = off_q;
        done_d     = done_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lcu_size_d = (cfg_lcu_size == 2'd3) ? 2'd2 : cfg_lcu_size;
                    lcu_x_d    = 3'd0;
                    lcu_y_d    = 3'd0;
                    row_d      = 7'd0;
                    col_d      = 7'd0;
                    par_addr_d = 6'd0;
                    done_d     = 1'b0;
                    state_d    = PAR;
                end
            end
            PAR: state_d = PARW;
            PARW: begin
                type_d  = par_data[23:22];
                band_d  = par_data[21:17];
                wo_d    = par_data[16];
                off_d   = par_data[15:0];
                state_d = STREAM;
            end
            STREAM: begin
                img_rd_d   = 1'b1;
                img_addr_d = cur_addr;
                if (col_q == s_last) begin
                    // Rows 0 and 1 prime the filter's line buffers and never wait on busy.
                    if (row_q < 7'd2) begin
                        row_d = row_q + 7'd1;
                        col_d = 7'd0;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    col_d = col_q + 7'd1;
                end
            end
            HOLD: begin
                if (!img_rd_q && !rd_d1_q && !in_en_q && busy) state_d = RESUME;
            end
            RESUME: begin
                if (!busy) begin
                    col_d = 7'd0;
                    if (row_q != s_last) begin
                        row_d   = row_q + 7'd1;
                        state_d = STREAM;
                    end else if (lcu_x_q == n_last && lcu_y_q == n_last) begin
                        row_d   = 7'd0;
                        state_d = DRAIN;
                    end else begin
                        row_d      = 7'd0;
                        lcu_x_d    = nx_x;
                        lcu_y_d    = nx_y;
                        par_addr_d = 6'(({3'b000, nx_y} << lg_n) | {3'b000, nx_x});
                        state_d    = PAR;
                    end
                end
            end
            DRAIN: begin
                if (finish) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lcu_size_q <= 2'd0;
            lcu_x_q    <= 3'd0;
            lcu_y_q    <= 3'd0;
            row_q      <= 7'd0;
            col_q      <= 7'd0;
            par_addr_q <= 6'd0;
            img_rd_q   <= 1'b0;
            img_addr_q <= '0;
            rd_d1_q    <= 1'b0;
            in_en_q    <= 1'b0;
            din_q      <= 8'd0;
            type_q     <= 2'd0;
            band_q     <= 5'd0;
            wo_q       <= 1'b0;
            off_q      <= 16'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lcu_size_q <= lcu_size_d;
            lcu_x_q    <= lcu_x_d;
            lcu_y_q    <= lcu_y_d;
            row_q      <= row_d;
            col_q      <= col_d;
            par_addr_q <= par_addr_d;
            img_rd_q   <= img_rd_d;
            img_addr_q <= img_addr_d;
            rd_d1_q    <= img_rd_q;
            in_en_q    <= rd_d1_q;
            if (rd_d1_q) din_q <= img_data;
            type_q     <= type_d;
            band_q     <= band_d;
            wo_q       <= wo_d;
            off_q      <= off_d;
            done_q     <= done_d;
        end
    end

    assign img_rd       = img_rd_q;
    assign img_addr     = img_addr_q;
    assign par_rd       = (state_q == PAR);
    assign par_addr     = par_addr_q;
    assign in_en        = in_en_q;
    assign din          = din_q;
    assign ipf_type     = type_q;
    assign ipf_band_pos = band_q;
    assign ipf_wo_class = wo_q;
    assign ipf_offset   = off_q;
    assign lcu_x        = lcu_x_q;
    assign lcu_y        = lcu_y_q;
    assign lcu_size     = lcu_size_q;
    assign done         = done_q;

endmodule
